// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: registered WIDTH-bit gate unit with eight selectable functions.
// Operands are taken through a valid/ready handshake. Results leave through a
// 2-entry in-order FIFO. A saturating counter tracks how many results were popped.
// Optional macro GATE_SWEEP_EN adds a sweep generator that replays the 00/01/10/11
// operand pattern with a captured gate op.

// One bit of the gate function. The top instantiates one per result bit.
module gate_unit_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    // Gate select: AND, OR, NAND, NOR, XOR, XNOR, NOT a, BUF a
    always_comb begin
        y = 1'b0;
        case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = ~(a & b);
            3'd3: y = ~(a | b);
            3'd4: y = a ^ b;
            3'd5: y = ~(a ^ b);
            3'd6: y = ~a;
            default: y = a;
        endcase
    end
endmodule

module gate_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] result_cnt,
    input  logic             sweep_start,
    input  logic [2:0]       sweep_op,
    output logic             sweep_busy,
    output logic             sweep_done
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] cnt_q;

    logic             push, pop, push_ext;
    logic             sweep_push;
    logic [2:0]       sweep_op_q;
    logic [WIDTH-1:0] sweep_a, sweep_b;
    logic [2:0]       push_op;
    logic [WIDTH-1:0] push_a, push_b, push_y;

`ifdef GATE_SWEEP_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;

    sweep_state_t state, state_nxt;
    logic [1:0]   idx, idx_nxt;
    logic [2:0]   sweep_op_nxt;

    // Sweep state, index and captured op
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            sweep_op_q <= 3'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            sweep_op_q <= sweep_op_nxt;
        end
    end

    // Sweep next-state and outputs. A push happens on every RUN cycle that has FIFO room.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        sweep_op_nxt = sweep_op_q;
        sweep_push   = 1'b0;
        sweep_busy   = 1'b0;
        sweep_done   = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    sweep_op_nxt = sweep_op;
                    idx_nxt      = 2'd0;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                sweep_busy = 1'b1;
                if (count < 2'd2) begin
                    sweep_push = 1'b1;
                    idx_nxt    = idx + 2'd1;
                    if (idx == 2'd3) state_nxt = DONE;
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sweep_a = {WIDTH{idx[1]}};
    assign sweep_b = {WIDTH{idx[0]}};
`else
    logic sweep_unused;
    assign sweep_unused = sweep_start ^ (^sweep_op);
    assign sweep_push   = 1'b0;
    assign sweep_busy   = 1'b0;
    assign sweep_done   = 1'b0;
    assign sweep_op_q   = 3'd0;
    assign sweep_a      = '0;
    assign sweep_b      = '0;
`endif

    // in_ready depends on state only, so a full FIFO never passes data through.
    assign in_ready  = (count < 2'd2) && !sweep_busy;
    assign push_ext  = in_valid && in_ready;
    assign push      = push_ext || sweep_push;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    assign push_op = sweep_push ? sweep_op_q : in_op;
    assign push_a  = sweep_push ? sweep_a    : in_a;
    assign push_b  = sweep_push ? sweep_b    : in_b;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gate_unit_lane u_lane (
            .op (push_op),
            .a  (push_a[i]),
            .b  (push_b[i]),
            .y  (push_y[i])
        );
    end

    // FIFO storage, pointers and occupancy. y_q mirrors the head and keeps its value when the FIFO empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            y_q    <= '0;
            cnt_q  <= '0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_y;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (count == 2'd0 && push)
                y_q <= push_y;
            else if (pop && count == 2'd2)
                y_q <= mem[~rd_ptr];
            else if (pop && push)
                y_q <= push_y;
        end
    end

    assign out_y      = y_q;
    assign out_zero   = out_valid && (y_q == '0);
    assign result_cnt = cnt_q;
endmodule

// File: tb/tb_gate_unit_pipe.sv
// Bench for gate_unit_pipe: directed steps with a scoreboard queue.
// A negedge monitor pushes the expected result on each handshake and compares on each pop or stall.
module tb_gate_unit_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic [CNT_W-1:0] result_cnt;
    logic             sweep_start = 1'b0;
    logic [2:0]       sweep_op = '0;
    logic             sweep_busy;
    logic             sweep_done;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_tab [8];

    gate_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .result_cnt (result_cnt),
        .sweep_start(sweep_start),
        .sweep_op   (sweep_op),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] gate_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: record pushes, compare the head on pops and stalls
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(gate_f(in_a, in_b, in_op));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk(out_ready ? "pop_y" : "stall_y", {24'd0, out_y}, {24'd0, exp_q[0]});
                    chk("out_zero", {31'd0, out_zero}, {31'd0, exp_q[0] == '0});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab[0] = 8'h30; exp_tab[1] = 8'hFC; exp_tab[2] = 8'hCF; exp_tab[3] = 8'h03;
        exp_tab[4] = 8'hCC; exp_tab[5] = 8'h33; exp_tab[6] = 8'h0F; exp_tab[7] = 8'hF0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", {24'd0, out_y}, 32'd0);
        chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result_cnt", {16'd0, result_cnt}, 32'd0);
        chk("rst_sweep_busy", {31'd0, sweep_busy}, 32'd0);

        // All eight ops on F0/3C, one cycle latency each
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            push(8'hF0, 8'h3C, 3'(op));
            @(negedge clk);
            chk("lat_valid", {31'd0, out_valid}, 32'd1);
            chk("op_table", {24'd0, out_y}, {24'd0, exp_tab[op]});
        end
        drain();
        chk("cnt_after_ops", {16'd0, result_cnt}, 32'd8);

        // Backpressure: two fill the FIFO, third is held
        out_ready = 1'b0;
        push(8'h00, 8'h01, 3'd3);
        push(8'h0F, 8'h00, 3'd3);
        @(negedge clk);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        fork
            push(8'h55, 8'h22, 3'd3);
        join_none
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        repeat (2) @(posedge clk); #1;
        chk("bp_drained", exp_q.size(), 32'd0);
        chk("cnt_after_bp", {16'd0, result_cnt}, 32'd11);

        // Simultaneous push/pop with one entry resident
        out_ready = 1'b0;
        push(8'h12, 8'h34, 3'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            if (i == 4) begin
                in_a = 8'hFF; in_b = 8'hFF; in_op = 3'd3;
            end else begin
                in_a = 8'(i * 17 + 1); in_b = ~8'(i * 3); in_op = 3'(i % 8);
            end
            @(negedge clk);
            chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
            chk("pp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        chk("cnt_after_pp", {16'd0, result_cnt}, 32'd22);

        // Reset with FIFO full
        out_ready = 1'b0;
        push(8'h01, 8'h02, 3'd4);
        push(8'h03, 8'h04, 3'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_cnt", {16'd0, result_cnt}, 32'd0);
        chk("mid_rst_y", {24'd0, out_y}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        push(8'hAA, 8'h55, 3'd4);
        @(negedge clk);
        chk("post_rst_lat", {31'd0, out_valid}, 32'd1);
        chk("post_rst_y", {24'd0, out_y}, 32'hFF);
        drain();

`ifdef GATE_SWEEP_EN
        // Sweep with NOR: FF, 00, 00, 00
        begin
            int busy_seen = 0;
            int done_cnt  = 0;
            exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            sweep_op = 3'd3;
            sweep_start = 1'b1;
            @(posedge clk); #1;
            sweep_start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (sweep_busy) begin
                    busy_seen++;
                    chk("sweep_in_ready", {31'd0, in_ready}, 32'd0);
                end
                if (sweep_done) done_cnt++;
            end
            chk("sweep_done_once", done_cnt, 32'd1);
            chk("sweep_busy_seen", {31'd0, busy_seen != 0}, 32'd1);
            drain();
            chk("cnt_after_sweep", {16'd0, result_cnt}, 32'd5);
        end
`else
        // Without the sweep feature the controls are inert
        sweep_op = 3'd3;
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("nosweep_busy", {31'd0, sweep_busy}, 32'd0);
            chk("nosweep_done", {31'd0, sweep_done}, 32'd0);
            chk("nosweep_valid", {31'd0, out_valid}, 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
